// File: rtl/lvds_rx_decoder.sv
// LVDS receive decoder: finds the 7-bit word boundary from the clock lane, realigns
// the four data lanes and unpacks RGB888 plus DE/VS/HS with lock tracking.
module lvds_rx_decoder #(
  parameter logic [6:0] CLK_PAT  = 7'b1100011,
  parameter int         LOCK_CNT = 16,
  parameter int         ERR_MAX  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  rxc_i,
  input  logic [6:0]  rxd0_i,
  input  logic [6:0]  rxd1_i,
  input  logic [6:0]  rxd2_i,
  input  logic [6:0]  rxd3_i,
  output logic        locked_o,
  output logic [2:0]  align_o,
  output logic        de_o,
  output logic        vs_o,
  output logic        hs_o,
  output logic [23:0] data_o
);

  typedef enum logic [1:0] {S_SEARCH, S_VERIFY, S_LOCKED} state_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0] ERR_LAST  = 8'(ERR_MAX - 1);

  function automatic logic [6:0] window7(input logic [13:0] cat, input logic [2:0] k);
    return cat[k +: 7];
  endfunction

  function automatic logic [5:0] window6(input logic [12:0] cat, input logic [2:0] k);
    return cat[k +: 6];
  endfunction

  function automatic logic [6:0] rev7(input logic [6:0] a);
    logic [6:0] w;
    for (int i = 0; i < 7; i++) w[i] = a[6 - i];
    return w;
  endfunction

  function automatic logic [5:0] rev6(input logic [5:0] a);
    logic [5:0] w;
    for (int i = 0; i < 6; i++) w[i] = a[5 - i];
    return w;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  logic [6:0]  w_rx   [5];
  logic [6:0]  r_cur  [5];
  logic [6:0]  r_prev [5];
  state_t      r_state;
  logic [2:0]  r_offset;
  logic [7:0]  r_match_cnt;
  logic [7:0]  r_err_cnt;
  logic [6:0]  r_al0, r_al1, r_al2;
  logic [5:0]  r_al3;
  logic [13:0] w_clk_cat;
  logic        w_hit;
  logic [2:0]  w_hit_k;
  logic        w_clk_ok;
  logic [6:0]  w_w0, w_w1, w_w2;
  logic [5:0]  w_w3;
  logic [23:0] w_pix;
  logic        w_lock_now;

  assign w_rx[0] = rxc_i;
  assign w_rx[1] = rxd0_i;
  assign w_rx[2] = rxd1_i;
  assign w_rx[3] = rxd2_i;
  assign w_rx[4] = rxd3_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: these lane arrays are a handful of flops, not a RAM, so they take the async reset.
      for (int i = 0; i < 5; i++) begin
        r_cur[i]  <= '0;
        r_prev[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking, so prev captures the old cur and the two form a real 2-word history.
      for (int i = 0; i < 5; i++) begin
        r_cur[i]  <= w_rx[i];
        r_prev[i] <= r_cur[i];
      end
    end
  end

  assign w_clk_cat = {r_prev[0], r_cur[0]};
  assign w_clk_ok  = (window7(w_clk_cat, r_offset) == CLK_PAT);

  always_comb begin
    // NOTE: defaults first so every path assigns these and no latch is inferred.
    w_hit   = 1'b0;
    w_hit_k = 3'd0;
    // Scan downward so the lowest matching offset is the one left standing.
    for (int k = 6; k >= 0; k--) begin
      if (window7(w_clk_cat, 3'(k)) == CLK_PAT) begin
        w_hit   = 1'b1;
        w_hit_k = 3'(k);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_SEARCH;
      r_offset    <= 3'd0;
      r_match_cnt <= 8'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_SEARCH: begin
          if (w_hit) begin
            r_state     <= S_VERIFY;
            r_offset    <= w_hit_k;
            r_match_cnt <= 8'd1;
            r_err_cnt   <= 8'd0;
          end
        end
        S_VERIFY: begin
          if (!w_clk_ok) begin
            r_state     <= S_SEARCH;
            r_match_cnt <= 8'd0;
            r_err_cnt   <= 8'd0;
          end else if (r_match_cnt >= LOCK_LAST) begin
            r_state     <= S_LOCKED;
            r_match_cnt <= 8'd0;
            r_err_cnt   <= 8'd0;
          end else begin
            r_match_cnt <= sat_inc(r_match_cnt);
          end
        end
        S_LOCKED: begin
          if (w_clk_ok) begin
            r_err_cnt <= 8'd0;
          end else if (r_err_cnt >= ERR_LAST) begin
            r_state     <= S_SEARCH;
            r_match_cnt <= 8'd0;
            r_err_cnt   <= 8'd0;
          end else begin
            r_err_cnt <= sat_inc(r_err_cnt);
          end
        end
        default: begin
          r_state     <= S_SEARCH;
          r_match_cnt <= 8'd0;
          r_err_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Lane 3 keeps only aligned bits [6:1]; bit 0 of that word is the unused w3[6].
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_al0 <= '0;
      r_al1 <= '0;
      r_al2 <= '0;
      r_al3 <= '0;
    end else begin
      r_al0 <= window7({r_prev[1], r_cur[1]}, r_offset);
      r_al1 <= window7({r_prev[2], r_cur[2]}, r_offset);
      r_al2 <= window7({r_prev[3], r_cur[3]}, r_offset);
      r_al3 <= window6({r_prev[4], r_cur[4][6:1]}, r_offset);
    end
  end

  assign w_w0 = rev7(r_al0);
  assign w_w1 = rev7(r_al1);
  assign w_w2 = rev7(r_al2);
  assign w_w3 = rev6(r_al3);

  assign w_pix = {w_w3[1:0], w_w0[5:0],
                  w_w3[3:2], w_w1[4:0], w_w0[6],
                  w_w3[5:4], w_w2[3:0], w_w1[6], w_w1[5]};

  assign w_lock_now = (r_state == S_LOCKED);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locked_o <= 1'b0;
      align_o  <= 3'd0;
      de_o     <= 1'b0;
      vs_o     <= 1'b0;
      hs_o     <= 1'b0;
      data_o   <= 24'd0;
    end else begin
      locked_o <= w_lock_now;
      align_o  <= r_offset;
      de_o     <= w_lock_now & w_w2[6];
      vs_o     <= w_lock_now & w_w2[5];
      hs_o     <= w_lock_now & w_w2[4];
      data_o   <= w_lock_now ? w_pix : 24'd0;
    end
  end

endmodule

// File: tb/tb_lvds_rx_decoder.sv
// Directed bench for lvds_rx_decoder: encodes pixels into rotated LVDS lane words
// and checks lock timing, alignment, decode, flywheel and reset behaviour.
module tb_lvds_rx_decoder;

  localparam logic [6:0] CLK_PAT = 7'b1100011;
  localparam int N = 80;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [6:0]  rxc_i, rxd0_i, rxd1_i, rxd2_i, rxd3_i;
  logic        locked_o;
  logic [2:0]  align_o;
  logic        de_o, vs_o, hs_o;
  logic [23:0] data_o;

  lvds_rx_decoder dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rxc_i   (rxc_i),
    .rxd0_i  (rxd0_i),
    .rxd1_i  (rxd1_i),
    .rxd2_i  (rxd2_i),
    .rxd3_i  (rxd3_i),
    .locked_o(locked_o),
    .align_o (align_o),
    .de_o    (de_o),
    .vs_o    (vs_o),
    .hs_o    (hs_o),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [23:0] pix [N];
  logic [2:0]  ctl [N];   // {de, vs, hs}
  bit          bad [N];   // clock-lane word replaced by zeros
  bit          b6  [N];   // value of the ignored w3[6]
  int          cur_k;

  typedef struct {
    int          k;
    logic [23:0] base;
    logic [23:0] step;
    int          lock_n;   // cycle index after which locked_o is first high
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_pix(input string name, input int p);
    check({name, " locked"}, {31'd0, locked_o}, 32'd1);
    check({name, " data"}, {8'd0, data_o}, {8'd0, pix[p]});
    check({name, " de/vs/hs"}, {29'd0, de_o, vs_o, hs_o}, {29'd0, ctl[p]});
  endtask

  task automatic check_dark(input string name);
    check({name, " locked"}, {31'd0, locked_o}, 32'd0);
    check({name, " data"}, {8'd0, data_o}, 32'd0);
    check({name, " de/vs/hs"}, {29'd0, de_o, vs_o, hs_o}, 32'd0);
  endtask

  function automatic logic [6:0] rev7(input logic [6:0] x);
    logic [6:0] y;
    for (int i = 0; i < 7; i++) y[i] = x[6 - i];
    return y;
  endfunction

  // Transmit-side packing of pixel n into aligned lane words {clk, l0, l1, l2, l3}.
  function automatic logic [34:0] aligned(input int n);
    logic [7:0] r, g, b;
    logic [6:0] w0, w1, w2, w3, c;
    {r, g, b} = pix[n];
    w0 = {g[0], r[5:0]};
    w1 = {b[1], b[0], g[5:1]};
    w2 = {ctl[n], b[5:2]};
    w3 = {b6[n], b[7:6], g[7:6], r[7:6]};
    c  = bad[n] ? 7'b0000000 : CLK_PAT;
    return {c, rev7(w0), rev7(w1), rev7(w2), rev7(w3)};
  endfunction

  task automatic drive(input int n);
    logic [34:0] a0, a1;
    logic [13:0] t;
    logic [6:0]  o [5];
    a0 = aligned(n);
    a1 = aligned((n + 1 < N) ? n + 1 : n);
    for (int l = 0; l < 5; l++) begin
      t    = {a0[34 - 7 * l -: 7], a1[34 - 7 * l -: 7]};
      o[l] = t[13 - cur_k -: 7];
    end
    rxc_i  = o[0];
    rxd0_i = o[1];
    rxd1_i = o[2];
    rxd2_i = o[3];
    rxd3_i = o[4];
  endtask

  // Presents word n before a rising edge, then returns just after that edge.
  task automatic cyc(input int n);
    @(negedge clk_i);
    drive(n);
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill(input logic [23:0] base, input logic [23:0] step,
                      input logic [2:0] ctl_fix, input bit toggle, input bit b6v);
    for (int n = 0; n < N; n++) begin
      pix[n] = base + step * 24'(n);
      ctl[n] = toggle ? 3'(n) : ctl_fix;
      bad[n] = 1'b0;
      b6[n]  = b6v;
    end
  endtask

  task automatic do_reset();
    rst_i  = 1'b1;
    rxc_i  = '0;
    rxd0_i = '0;
    rxd1_i = '0;
    rxd2_i = '0;
    rxd3_i = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 24'h000000, 24'h010203, 17};
    tbl[1] = '{1, 24'h102030, 24'h030507, 18};
    tbl[2] = '{2, 24'h7F80FF, 24'h112233, 18};
    tbl[3] = '{3, 24'hFFFFFF, 24'h000001, 18};
    tbl[4] = '{4, 24'h0055AA, 24'h090909, 18};
    tbl[5] = '{5, 24'hC0FFEE, 24'h101010, 18};
    tbl[6] = '{6, 24'h3C3C3C, 24'h0A0B0C, 18};

    rst_i  = 1'b1;
    rxc_i  = '0;
    rxd0_i = '0;
    rxd1_i = '0;
    rxd2_i = '0;
    rxd3_i = '0;
    #2;
    check_dark("reset");
    check("reset align", {29'd0, align_o}, 32'd0);

    // Constant pixel, offset 3: lock appears right after edge 19.
    fill(24'hA5C33C, 24'h0, 3'b100, 1'b0, 1'b0);
    cur_k = 3;
    do_reset();
    for (int n = 0; n <= 18; n++) begin
      cyc(n);
      if (n == 2)  check_dark("t1 early");
      if (n == 17) check_dark("t1 edge18");
      if (n == 18) begin
        check("t1 locked", {31'd0, locked_o}, 32'd1);
        check("t1 align", {29'd0, align_o}, 32'd3);
        check("t1 data", {8'd0, data_o}, 32'h00A5C33C);
        check("t1 de", {31'd0, de_o}, 32'd1);
      end
    end

    // Offset sweep with incrementing pixels and toggling control bits.
    for (int i = 0; i < 7; i++) begin
      fill(tbl[i].base, tbl[i].step, 3'b000, 1'b1, tbl[i].k[0]);
      cur_k = tbl[i].k;
      do_reset();
      for (int n = 0; n <= tbl[i].lock_n + 4; n++) begin
        cyc(n);
        if (n == tbl[i].lock_n - 1)
          check_dark($sformatf("sweep k=%0d prelock", tbl[i].k));
        if (n >= tbl[i].lock_n) begin
          check_pix($sformatf("sweep k=%0d n=%0d", tbl[i].k, n), n - 2);
          check($sformatf("sweep k=%0d align", tbl[i].k), {29'd0, align_o}, 32'(tbl[i].k));
        end
      end
    end

    // One bad clock word while match_cnt = 10 sends VERIFY back to SEARCH.
    fill(24'h123456, 24'h000101, 3'b000, 1'b1, 1'b0);
    bad[11] = 1'b1;
    cur_k = 3;
    do_reset();
    for (int n = 0; n <= 30; n++) begin
      cyc(n);
      if (n == 18) check_dark("verify-err n=18");
      if (n == 28) check_dark("verify-err n=28");
      if (n == 29) begin
        check_pix("verify-err relock", 27);
        check("verify-err align", {29'd0, align_o}, 32'd3);
      end
    end

    // Flywheel: 3 bad words are tolerated, 4 drop lock; w3[6] set throughout.
    fill(24'hFEDCBA, 24'h0F0F0F, 3'b000, 1'b1, 1'b1);
    for (int n = 25; n <= 27; n++) bad[n] = 1'b1;
    for (int n = 33; n <= 36; n++) bad[n] = 1'b1;
    cur_k = 5;
    do_reset();
    for (int n = 0; n <= 56; n++) begin
      cyc(n);
      if (n >= 18 && n <= 37) check_pix($sformatf("flywheel n=%0d", n), n - 2);
      if (n == 38) check_dark("unlock n=38");
      if (n == 53) check_dark("relock n=53");
      if (n >= 54) check_pix($sformatf("relock n=%0d", n), n - 2);
    end
    check("relock align", {29'd0, align_o}, 32'd5);

    // Asynchronous reset while locked: outputs clear with no clock edge.
    #2;
    rst_i = 1'b1;
    #1;
    check_dark("async reset");
    check("async reset align", {29'd0, align_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int n = 0; n <= 18; n++) begin
      cyc(n);
      if (n == 17) check_dark("post-reset n=17");
      if (n == 18) begin
        check_pix("post-reset lock", 16);
        check("post-reset align", {29'd0, align_o}, 32'd5);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lvds_rx_decoder.md
# lvds_rx_decoder

Receive-side counterpart of the LCD-to-LVDS transmit packer. Takes the five 7-bit parallel words per pixel clock (one clock lane, four data lanes) from the 1:7 deserializer, whose word boundary is arbitrary. It finds the word boundary from the clock-lane pattern and realigns all lanes. It then unpacks the 24-bit RGB pixel plus DE/VS/HS and flags lock status to the downstream video pipeline.

## Interface
Parameters:
- CLK_PAT, 7'b1100011, clock-lane word in aligned form.
- LOCK_CNT, 16, consecutive matching words needed to declare lock (1..255).
- ERR_MAX, 4, consecutive mismatches in LOCKED before lock is dropped (1..255).

Ports:
- clk_i  in  1  pixel clock; one word per lane per cycle.
- rst_i  in  1  reset, asynchronous, active-high.
- rxc_i  in  7  clock-lane word from deserializer.
- rxd0_i..rxd3_i  in  7 each  data-lane words from deserializer.
- locked_o  out  1  word alignment locked.
- align_o  out  3  selected bit offset k (0..6).
- de_o  out  1  recovered DE.
- vs_o  out  1  recovered VS.
- hs_o  out  1  recovered HS.
- data_o  out  24  {red, green, blue}, blue in the LSBs.

## Operation
- Input stage: each lane registers cur_q <= rx*_i and prev_q <= cur_q.
- Windowing: cat = {prev_q, cur_q} (14 bits). window(k) = cat[6+k:k], k = 0..6. The same k applies to all five lanes.
- FSM states are SEARCH, VERIFY and LOCKED. The reset state is SEARCH.
- SEARCH: compare window(k) of the clock lane with CLK_PAT for all k. On any match, latch the lowest matching k into the offset register, set match_cnt = 1 and go to VERIFY. With no match, stay in SEARCH.
- VERIFY: if the clock-lane window(offset) equals CLK_PAT, increment match_cnt. When match_cnt reaches LOCK_CNT, go to LOCKED. On a mismatch, go to SEARCH. The new search starts on the following cycle; the offset is not re-evaluated in the mismatch cycle.
- LOCKED: a match clears err_cnt. A mismatch increments err_cnt. When err_cnt reaches ERR_MAX, go to SEARCH and clear err_cnt. Decoding continues during mismatch cycles (flywheel).
- Counters saturate and never wrap. Both counters are cleared on every state entry, except that match_cnt is set to 1 on entry to VERIFY.
- Aligned word a = window(offset), registered per lane. Decoding uses w = bit-reverse of a (w[i] = a[6-i]).
- Lane 0: w0[5:0] = red[5:0], w0[6] = green[0].
- Lane 1: w1[4:0] = green[5:1], w1[5] = blue[0], w1[6] = blue[1].
- Lane 2: w2[3:0] = blue[5:2], w2[4] = hs, w2[5] = vs, w2[6] = de.
- Lane 3: w3[1:0] = red[7:6], w3[3:2] = green[7:6], w3[5:4] = blue[7:6], w3[6] is ignored.
- Output gating: when locked_o = 0, de_o, vs_o, hs_o and data_o are forced to 0 in the same cycle. This applies in SEARCH and VERIFY, and in the cycle lock is dropped.

## Timing
- Reset (asynchronous): all registers clear. State is SEARCH, offset = 0, counters = 0, all outputs 0.
- Reset mid-stream forces the same values immediately. Realignment restarts from SEARCH after release.
- Data latency is 2 clocks. The input sampled at edge t, together with the sample at edge t-1 when k > 0, forms the aligned word at edge t+1. The decoded outputs follow at edge t+2.
- locked_o and align_o are registered in the output stage, so they stay cycle-consistent with data_o.
- Minimum time to lock with a continuous valid stream and k > 0 is LOCK_CNT + 2 edges after reset release for the state change, plus 1 edge for output. With LOCK_CNT = 16, locked_o is high after edge 19.
- Unlock: locked_o falls in the output cycle matching the ERR_MAX-th consecutive bad word.

## Test plan
- Reset, then a valid stream rotated by k = 3 with constant pixel 0xA5C3_3C and DE = 1 -> align_o = 3, locked_o rises after edge 19, data_o = 0xA5C33C, de_o = 1.
- Sweep k = 0..6 with an incrementing pixel pattern -> each k locks, align_o = k, and data_o equals the transmitted pixel delayed by exactly 2 clocks.
- Corrupt the clock lane for 1 word during VERIFY, at match_cnt = 10 -> return to SEARCH; lock is reached only after 16 further good words.
- While LOCKED, corrupt the clock lane for 3 words, then for 4 words (ERR_MAX = 4) -> 3 errors: locked_o stays 1 and data is still decoded. 4 errors: locked_o and data_o drop to 0, then relock after 16 good words.
- Toggle VS/HS/DE bits in lane 2 while locked -> vs_o, hs_o and de_o follow with 2-clock latency. Lane 3 bit w3[6] = 1 has no effect on any output.
- Assert rst_i asynchronously mid-frame while locked -> all outputs 0 immediately without a clock edge, then normal relock after release.
